mux_4to1: RTL and testbench
===========================

# mux_4to1

Registered 4-to-1 multiplexer with a parameterised data width. Each enabled cycle it captures one of four data inputs, chosen by a 2-bit select, into an output register, and flags the result with a valid bit. It serves as a generic steering element in datapaths that need a clean, glitch-free selected value one cycle after the choice is presented.

## Interface

Parameters:
- WIDTH, default 1: bit width of each data input and of the output.

Ports:
- Clocking is decided: one clock; reset is synchronous and active-high.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset; sampled on rising clk.
- en  input  1  capture enable; when high, the selected input is registered this cycle.
- i0  input  WIDTH  data input, chosen when select = 2'b00.
- i1  input  WIDTH  data input, chosen when select = 2'b01.
- i2  input  WIDTH  data input, chosen when select = 2'b10.
- i3  input  WIDTH  data input, chosen when select = 2'b11.
- select  input  2  input selector.
- y  output  WIDTH  registered selected data.
- y_valid  output  1  high for exactly the cycle after a capture, covering the value y holds then.
- sel_q  output  2  select value registered alongside y, for downstream tagging.

## Operation

- Selection is a full decode of select: 00 to i0, 01 to i1, 10 to i2, 11 to i3. There is no default or illegal code.
- Each data bit is routed independently. No arithmetic, no width change.
- On a rising clk with rst = 1: y <= 0, sel_q <= 2'b00, y_valid <= 0. Reset overrides en.
- On a rising clk with rst = 0 and en = 1: y <= selected input, sel_q <= select, y_valid <= 1.
- On a rising clk with rst = 0 and en = 0: y and sel_q hold their values, and y_valid <= 0.
- Inputs with X or Z values are not resolved. X on the chosen input propagates to y. X on an unchosen input must not affect y.
- No internal state exists beyond y, sel_q and y_valid.

## Timing

- Latency is 1 cycle. A value presented together with en = 1 at edge N appears on y after edge N.
- Throughput is one capture per cycle. Back-to-back en keeps y_valid continuously high.
- All outputs come directly from registers. No combinational path runs from any input to any output.
- Reset values: y = {WIDTH{1'b0}}, sel_q = 2'b00, y_valid = 0.
- Reset mid-stream: a capture presented in the same cycle as rst is discarded, and y_valid is low on the following cycle.
- Inputs that change between clock edges have no effect until the next edge.
- Inputs must meet setup and hold relative to the clk rising edge.

## Test plan

- One-hot sweep, WIDTH=1, en=1: (i0..i3 = 1,0,0,0, select 00), then (0,1,0,0, select 01), then (0,0,1,0, select 10), then (0,0,0,1, select 11). y = 1 after each edge, y_valid = 1, and sel_q tracks select.
- Inverse sweep: set the chosen input to 0 and the other three to 1 for each select code. y = 0 each cycle, which proves unchosen inputs are ignored.
- Hold: capture i2 = 1 with select 10, then drop en and toggle all inputs and select for 3 cycles. y stays 1, sel_q stays 10, y_valid = 0.
- Reset: with y = 1, assert rst together with en = 1. Next cycle y = 0, sel_q = 00, y_valid = 0. Deassert rst and the next capture works normally.
- Wide data, WIDTH=8: i0 = 8'hA5, i1 = 8'h3C, i2 = 8'hFF, i3 = 8'h00, cycling select 00 to 11 with en = 1. y = A5, 3C, FF, 00 on consecutive cycles.
- Latency: change select mid-cycle with no clock edge. y is unchanged until the next rising clk.

Source files
------------

// File: rtl/mux_4to1.sv
// Registered 4-to-1 multiplexer: on each enabled clock edge captures the input chosen by
// select into y, records select in sel_q, and raises y_valid for the following cycle.
module mux_4to1 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [1:0]       select,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  output logic [1:0]       sel_q
);

  logic [WIDTH-1:0] mux_d;

  always_comb begin
    mux_d = '0;
    unique case (select)
      2'b00: mux_d = i0;
      2'b01: mux_d = i1;
      2'b10: mux_d = i2;
      2'b11: mux_d = i3;
      default: mux_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y       <= '0;
      sel_q   <= 2'b00;
      y_valid <= 1'b0;
    end else if (en) begin
      y       <= mux_d;
      sel_q   <= select;
      y_valid <= 1'b1;
    end else begin
      y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_4to1.sv
// Self-checking bench for mux_4to1: an 8-bit and a 1-bit instance share control inputs and
// are compared every cycle against an array-indexed reference model plus literal checks.
module tb_mux_4to1;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [1:0] select;
  logic [7:0] din [4];

  logic [7:0] y8;
  logic       v8;
  logic [1:0] s8;
  logic [0:0] y1;
  logic       v1;
  logic [1:0] s1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux_4to1 #(.WIDTH(8)) dut_w8 (
    .clk(clk), .rst(rst), .en(en),
    .i0(din[0]), .i1(din[1]), .i2(din[2]), .i3(din[3]),
    .select(select), .y(y8), .y_valid(v8), .sel_q(s8)
  );

  mux_4to1 #(.WIDTH(1)) dut_w1 (
    .clk(clk), .rst(rst), .en(en),
    .i0(din[0][0:0]), .i1(din[1][0:0]), .i2(din[2][0:0]), .i3(din[3][0:0]),
    .select(select), .y(y1), .y_valid(v1), .sel_q(s1)
  );

  // Reference model: the selected value is simply the array entry indexed by select.
  logic [7:0] m_y   = '0;
  logic [1:0] m_sel = '0;
  logic       m_v   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_y <= '0; m_sel <= '0; m_v <= 1'b0;
    end else if (en) begin
      m_y <= din[select]; m_sel <= select; m_v <= 1'b1;
    end else begin
      m_v <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  bit cmp_on = 1'b1;
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("w8.y", 32'(y8), 32'(m_y));
      chk("w8.y_valid", 32'(v8), 32'(m_v));
      chk("w8.sel_q", 32'(s8), 32'(m_sel));
      chk("w1.y", 32'(y1), 32'(m_y[0]));
      chk("w1.y_valid", 32'(v1), 32'(m_v));
      chk("w1.sel_q", 32'(s1), 32'(m_sel));
    end
  end

  // Drive one cycle's inputs just after a falling edge, then advance past the next rising edge.
  task automatic cyc(input logic r, input logic e, input logic [1:0] s,
                     input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] c, input logic [7:0] d);
    rst = r; en = e; select = s;
    din[0] = a; din[1] = b; din[2] = c; din[3] = d;
    @(negedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; select = 2'b11;
    din[0] = 8'hFF; din[1] = 8'hFF; din[2] = 8'hFF; din[3] = 8'hFF;
    @(negedge clk); #1;
    cyc(1, 1, 2'b11, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    chk("reset.y", 32'(y8), 32'h0);
    chk("reset.sel_q", 32'(s8), 32'h0);
    chk("reset.valid", 32'(v8), 32'h0);

    // One-hot sweep on bit 0
    for (int unsigned k = 0; k < 4; k++) begin
      logic [7:0] v [4];
      for (int unsigned j = 0; j < 4; j++) v[j] = (j == k) ? 8'h01 : 8'h00;
      cyc(0, 1, 2'(k), v[0], v[1], v[2], v[3]);
      chk("onehot.y1", 32'(y1), 32'h1);
      chk("onehot.valid", 32'(v1), 32'h1);
      chk("onehot.sel_q", 32'(s1), 32'(k));
    end

    // Inverse sweep: unchosen inputs all ones
    for (int unsigned k = 0; k < 4; k++) begin
      logic [7:0] v [4];
      for (int unsigned j = 0; j < 4; j++) v[j] = (j == k) ? 8'h00 : 8'hFF;
      cyc(0, 1, 2'(k), v[0], v[1], v[2], v[3]);
      chk("inverse.y8", 32'(y8), 32'h0);
    end

    // Hold with en low
    cyc(0, 1, 2'b10, 8'h00, 8'h00, 8'h01, 8'h00);
    for (int unsigned k = 0; k < 3; k++) begin
      cyc(0, 0, 2'(k), 8'hFF, 8'hFF, 8'h00, 8'hFF);
      chk("hold.y1", 32'(y1), 32'h1);
      chk("hold.sel_q", 32'(s1), 32'h2);
      chk("hold.valid", 32'(v1), 32'h0);
    end

    // Reset mid-stream overrides a capture
    cyc(0, 1, 2'b01, 8'h00, 8'h5A, 8'h00, 8'h00);
    chk("pre_reset.y8", 32'(y8), 32'h5A);
    cyc(1, 1, 2'b11, 8'h00, 8'h00, 8'h00, 8'hC3);
    chk("mid_reset.y8", 32'(y8), 32'h0);
    chk("mid_reset.sel_q", 32'(s8), 32'h0);
    chk("mid_reset.valid", 32'(v8), 32'h0);
    cyc(0, 1, 2'b11, 8'h00, 8'h00, 8'h00, 8'hC3);
    chk("post_reset.y8", 32'(y8), 32'hC3);
    chk("post_reset.valid", 32'(v8), 32'h1);

    // Wide data cycling the select
    cyc(0, 1, 2'b00, 8'hA5, 8'h3C, 8'hFF, 8'h00);
    chk("wide.sel00", 32'(y8), 32'hA5);
    cyc(0, 1, 2'b01, 8'hA5, 8'h3C, 8'hFF, 8'h00);
    chk("wide.sel01", 32'(y8), 32'h3C);
    cyc(0, 1, 2'b10, 8'hA5, 8'h3C, 8'hFF, 8'h00);
    chk("wide.sel10", 32'(y8), 32'hFF);
    cyc(0, 1, 2'b11, 8'hA5, 8'h3C, 8'hFF, 8'h00);
    chk("wide.sel11", 32'(y8), 32'h00);

    // Latency: mid-cycle input change does not reach y before the next rising edge
    rst = 0; en = 1; select = 2'b00;
    #2;
    chk("latency.y8", 32'(y8), 32'h00);
    chk("latency.sel_q", 32'(s8), 32'h3);
    @(negedge clk); #1;
    chk("latency.after_edge", 32'(y8), 32'hA5);

    // Randomized traffic
    for (int unsigned k = 0; k < 400; k++) begin
      cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), 2'($urandom),
          8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end

    @(negedge clk); #1;
    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
